// File: rtl/obstacle_buffer.sv
// obstacle_buffer
// Circular buffer of upcoming obstacles for a scrolling game world.
// In IDLE the producer pushes entries (nondecreasing distance order).
// A new_frame pulse streams every stored entry out, one per cycle,
// oldest first. The world then scrolls: each entry's distance drops by
// SPEED, and entries that have reached the player are popped from the head.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   new_frame        one-cycle frame start pulse
//   freeze           game over: stream only, skip the scroll pass
//   in_obstacle      pushed entry {type[15:13], lane[12:11], distance[10:0]}
//   in_valid/ready   push handshake (ready only in IDLE and not full)
//   obstacle         streamed entry, qualified by obstacle_valid
//   firstrow         streamed entry is closer than HALF_BLOCK_LENGTH
//   count            number of occupied entries
//   frame_done       one-cycle pulse when the frame has been processed
//   overrun          sticky: new_frame seen while busy
module obstacle_buffer #(
  parameter int DEPTH             = 16,
  parameter int SPEED             = 1,
  parameter int HALF_BLOCK_LENGTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   new_frame,
  input  logic                   freeze,
  input  logic [15:0]            in_obstacle,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [15:0]            obstacle,
  output logic                   obstacle_valid,
  output logic                   firstrow,
  output logic [$clog2(DEPTH):0] count,
  output logic                   frame_done,
  output logic                   overrun
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [10:0]   SPEED_D = 11'(SPEED);
  localparam logic [11:0]   HALF_D  = 12'(HALF_BLOCK_LENGTH);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_SCROLL} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [15:0]     r_mem [DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [PW-1:0]   r_ptr;        // walk pointer shared by STREAM and SCROLL
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   r_idx;        // entries already streamed this frame
  logic [CW-1:0]   r_remaining;  // entries still to visit in SCROLL
  logic [15:0]     r_obstacle;
  logic            r_valid;
  logic            r_firstrow;
  logic            r_frame_done;
  logic            r_overrun;

  logic            w_push;
  logic [15:0]     w_first;
  logic [15:0]     w_cur;
  logic            w_below_speed;
  logic            w_expired;
  logic [10:0]     w_dist_dec;
  logic            w_stream_done;
  logic            w_scroll_active;

  assign in_ready        = (r_state == S_IDLE) && (r_count < DEPTH_C);
  assign w_push          = in_valid && in_ready;
  // A push in the new_frame cycle into an empty buffer is not yet in
  // memory, so the first streamed entry is bypassed from the input.
  assign w_first         = (r_count == '0) ? in_obstacle : r_mem[r_head];
  assign w_cur           = r_mem[r_ptr];
  assign w_below_speed   = (w_cur[10:0] < SPEED_D);
  // Expired entries are contiguous at head: while every visited entry has
  // been popped the walk pointer still equals head.
  assign w_expired       = w_below_speed && (r_ptr == r_head);
  // Saturate so a stray out-of-order entry can never wrap to 2047.
  assign w_dist_dec      = w_below_speed ? 11'd0 : (w_cur[10:0] - SPEED_D);
  assign w_stream_done   = (r_idx == r_count);
  assign w_scroll_active = (r_state == S_SCROLL) && (r_remaining != '0);

  function automatic logic is_firstrow(input logic [15:0] e);
    return ({1'b0, e[10:0]} < HALF_D);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (new_frame) w_state_next = S_STREAM;
      S_STREAM: if (w_stream_done) w_state_next = freeze ? S_IDLE : S_SCROLL;
      S_SCROLL: if (r_remaining == '0) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Entry storage: no reset needed, count/pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_tail] <= in_obstacle;
    else if (w_scroll_active && !w_expired)
      r_mem[r_ptr] <= {w_cur[15:11], w_dist_dec};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_ptr        <= '0;
      r_count      <= '0;
      r_idx        <= '0;
      r_remaining  <= '0;
      r_obstacle   <= '0;
      r_valid      <= 1'b0;
      r_firstrow   <= 1'b0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (new_frame && (r_state != S_IDLE)) r_overrun <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_push) begin
            r_tail  <= r_tail + 1'b1;
            r_count <= r_count + 1'b1;
          end
          if (new_frame) begin
            r_ptr <= r_head + 1'b1;
            if ((r_count != '0) || w_push) begin
              r_obstacle <= w_first;
              r_firstrow <= is_firstrow(w_first);
              r_valid    <= 1'b1;
              r_idx      <= CW'(1);
            end else begin
              r_idx <= '0;
            end
          end
        end
        S_STREAM: begin
          if (!w_stream_done) begin
            r_obstacle <= w_cur;
            r_firstrow <= is_firstrow(w_cur);
            r_valid    <= 1'b1;
            r_ptr      <= r_ptr + 1'b1;
            r_idx      <= r_idx + 1'b1;
          end else begin
            r_valid <= 1'b0;
            if (freeze) begin
              r_frame_done <= 1'b1;
            end else begin
              r_ptr       <= r_head;
              r_remaining <= r_count;
            end
          end
        end
        S_SCROLL: begin
          if (r_remaining == '0) begin
            r_frame_done <= 1'b1;
          end else begin
            if (w_expired) begin
              r_head  <= r_head + 1'b1;
              r_count <= r_count - 1'b1;
            end
            r_ptr       <= r_ptr + 1'b1;
            r_remaining <= r_remaining - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign obstacle       = r_obstacle;
  assign obstacle_valid = r_valid;
  assign firstrow       = r_firstrow;
  assign count          = r_count;
  assign frame_done     = r_frame_done;
  assign overrun        = r_overrun;

endmodule

// File: tb/tb_obstacle_buffer.sv
// Scoreboard bench for obstacle_buffer: stimulus pushes expected streamed
// entries into a queue, a monitor pops and compares on every obstacle_valid.
module tb_obstacle_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        new_frame = 1'b0;
  logic        freeze = 1'b0;
  logic [15:0] in_obstacle = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] obstacle;
  logic        obstacle_valid;
  logic        firstrow;
  logic [4:0]  count;
  logic        frame_done;
  logic        overrun;

  int errors = 0;
  int checks = 0;
  int fd_count = 0;
  logic [16:0] exp_q[$];
  logic [16:0] mon_exp;

  always #5 clk = ~clk;

  obstacle_buffer #(.DEPTH(16), .SPEED(1), .HALF_BLOCK_LENGTH(64)) dut (
    .clk(clk), .rst(rst), .new_frame(new_frame), .freeze(freeze),
    .in_obstacle(in_obstacle), .in_valid(in_valid), .in_ready(in_ready),
    .obstacle(obstacle), .obstacle_valid(obstacle_valid), .firstrow(firstrow),
    .count(count), .frame_done(frame_done), .overrun(overrun)
  );

  function automatic logic [15:0] mk(input int t, input int l, input int d);
    return {3'(t), 2'(l), 11'(d)};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  task automatic expect_entry(input logic [15:0] e, input bit fr);
    exp_q.push_back({fr, e});
  endtask

  // Monitor: one comparison per streamed entry.
  always @(negedge clk) begin
    if (frame_done) fd_count++;
    if (!rst && obstacle_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL stream_extra: got obstacle=%h firstrow=%b, none expected", obstacle, firstrow);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({firstrow, obstacle} !== mon_exp) begin
          errors++;
          $display("FAIL stream: got obstacle=%h firstrow=%b expected obstacle=%h firstrow=%b",
                   obstacle, firstrow, mon_exp[15:0], mon_exp[16]);
        end else begin
          $display("ok   stream obstacle=%h firstrow=%b", obstacle, firstrow);
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_count", count, 0);
    check("reset_in_ready", in_ready, 1);
  endtask

  task automatic push(input logic [15:0] v);
    in_valid = 1'b1;
    in_obstacle = v;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Start a frame and wait (bounded) for frame_done; lat counts negedges.
  task automatic run_frame(input bit frz, input int n, input bit extra_nf, output int lat);
    bit got;
    @(posedge clk);
    #1;
    freeze = frz;
    new_frame = 1'b1;
    @(posedge clk);
    #1 new_frame = 1'b0;
    lat = 0;
    got = 0;
    while (!got && lat < 100) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        check("first_valid_next_cycle", obstacle_valid, int'(n > 0));
        if (extra_nf) new_frame = 1'b1;
      end
      if (lat == 2 && extra_nf) new_frame = 1'b0;
      if (frame_done) got = 1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL frame_done_timeout: got no pulse within %0d cycles, required one", lat);
    end
    freeze = 1'b0;
  endtask

  task automatic frame(input bit frz, input int n, input bit extra_nf,
                       input int exp_count, output int lat);
    int fd0;
    fd0 = fd_count;
    run_frame(frz, n, extra_nf, lat);
    repeat (3) @(negedge clk);
    check("frame_done_pulses", fd_count - fd0, 1);
    check("count_after_frame", count, exp_count);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat;
    int fd0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_obstacle_valid", obstacle_valid, 0);
    check("rst_obstacle", obstacle, 0);
    check("rst_firstrow", firstrow, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overrun", overrun, 0);
    do_reset();

    // Basic stream + scroll: 0x200, 0x040, 0x03F
    push(mk(1, 0, 'h200));
    push(mk(2, 1, 'h040));
    push(mk(3, 2, 'h03F));
    check("count_3", count, 3);
    expect_entry(mk(1, 0, 'h200), 0);
    expect_entry(mk(2, 1, 'h040), 0);
    expect_entry(mk(3, 2, 'h03F), 1);
    frame(0, 3, 0, 3, lat);
    expect_entry(mk(1, 0, 'h1FF), 0);
    expect_entry(mk(2, 1, 'h03F), 1);
    expect_entry(mk(3, 2, 'h03E), 1);
    frame(1, 3, 0, 3, lat);

    // Distance-0 entries popped, no underflow
    do_reset();
    push(mk(0, 0, 0));
    push(mk(1, 1, 0));
    push(mk(2, 2, 5));
    expect_entry(mk(0, 0, 0), 1);
    expect_entry(mk(1, 1, 0), 1);
    expect_entry(mk(2, 2, 5), 1);
    frame(0, 3, 0, 1, lat);
    expect_entry(mk(2, 2, 4), 1);
    frame(1, 1, 0, 1, lat);

    // Full buffer, rejected push, wrap of tail and stream pointer
    do_reset();
    for (int i = 0; i < 16; i++) push(mk(i % 8, i % 4, i));
    @(negedge clk);
    check("full_count", count, 16);
    check("full_in_ready", in_ready, 0);
    push(mk(7, 3, 99));
    @(negedge clk);
    check("full_reject_count", count, 16);
    for (int i = 0; i < 16; i++) expect_entry(mk(i % 8, i % 4, i), 1);
    frame(0, 16, 0, 15, lat);
    push(mk(7, 3, 40));
    @(negedge clk);
    check("wrap_push_count", count, 16);
    for (int i = 1; i < 16; i++) expect_entry(mk(i % 8, i % 4, i - 1), 1);
    expect_entry(mk(7, 3, 40), 1);
    frame(0, 16, 0, 15, lat);
    for (int i = 2; i < 16; i++) expect_entry(mk(i % 8, i % 4, i - 2), 1);
    expect_entry(mk(7, 3, 39), 1);
    frame(1, 15, 0, 15, lat);

    // Frozen: stream only, distances unchanged, no scroll pass
    do_reset();
    push(mk(1, 1, 100));
    push(mk(2, 0, 30));
    expect_entry(mk(1, 1, 100), 0);
    expect_entry(mk(2, 0, 30), 1);
    frame(1, 2, 0, 2, lat);
    check("frozen_no_scroll_latency", int'(lat <= 4), 1);
    expect_entry(mk(1, 1, 100), 0);
    expect_entry(mk(2, 0, 30), 1);
    frame(1, 2, 0, 2, lat);

    // Overrun during STREAM, then reset mid-SCROLL
    do_reset();
    push(mk(0, 0, 10));
    push(mk(0, 1, 20));
    push(mk(0, 2, 30));
    expect_entry(mk(0, 0, 10), 1);
    expect_entry(mk(0, 1, 20), 1);
    expect_entry(mk(0, 2, 30), 1);
    frame(0, 3, 1, 3, lat);
    check("overrun_set", overrun, 1);
    check("idle_after_overrun_in_ready", in_ready, 1);
    expect_entry(mk(0, 0, 9), 1);
    expect_entry(mk(0, 1, 19), 1);
    expect_entry(mk(0, 2, 29), 1);
    fd0 = fd_count;
    @(posedge clk);
    #1 new_frame = 1'b1;
    @(posedge clk);
    #1 new_frame = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_no_frame_done", fd_count - fd0, 0);
    check("abort_count", count, 0);
    check("abort_overrun", overrun, 0);
    check("abort_in_ready", in_ready, 1);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
